gate_vector_checker: RTL
========================

GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, giving the number of cycles a vector is held before sampling; legal values are 1..15, and 0 SHALL behave as 1.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 Port start, input, 1 bit: begin a 4-vector check run.
REQ-006 Port ra, input, 1 bit: AND result returned by the downstream gate stage.
REQ-007 Port rb, input, 1 bit: NAND result returned by the downstream gate stage.
REQ-008 Port a, output, 1 bit: operand a driven to the gate stage (registered).
REQ-009 Port b, output, 1 bit: operand b driven to the gate stage (registered).
REQ-010 Port busy, output, 1 bit: high while a run is in progress.
REQ-011 Port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-012 Port pass, output, 1 bit: result of the last completed run (1 = zero errors).
REQ-013 Port err_count, output, 3 bits: mismatches in the current or last run (0..4).
REQ-014 Port vec_idx, output, 2 bits: index of the vector currently driven.

Function
REQ-015 The vector order SHALL be idx 0: a=0,b=0; idx 1: a=0,b=1; idx 2: a=1,b=0; idx 3: a=1,b=1, i.e. {a,b}=vec_idx.
REQ-016 The expected response SHALL be ra=a&b and rb=~(a&b); a mismatch on either bit SHALL count as one error for that vector.
REQ-017 The FSM SHALL have the states IDLE, WAIT, SAMPLE and DONE.
REQ-018 IDLE + start=1: at the next edge the block SHALL set vec_idx=0, {a,b}=00, err_count=0, busy=1, load the settle counter with SETTLE, and go to WAIT.
REQ-019 WAIT SHALL hold for exactly SETTLE cycles and then go to SAMPLE.
REQ-020 SAMPLE SHALL compare ra/rb against the expected values and increment err_count on a mismatch; if vec_idx=3 it SHALL go to DONE, otherwise it SHALL increment vec_idx, drive the next vector, reload the counter, and go to WAIT.
REQ-021 DONE SHALL assert done=1 for one cycle, update pass=(err_count==0), clear busy, hold err_count, and go to IDLE.
REQ-022 Latency: with start sampled at edge 0, done SHALL be high in cycle 4*(SETTLE+1)+1, which is cycle 9 for SETTLE=1.
REQ-023 start SHALL be ignored while busy=1 or in DONE; start held high SHALL launch back-to-back runs, the next one starting the cycle after DONE.
REQ-024 Outside SAMPLE, err_count SHALL change only when cleared by a new run; it SHALL saturate at 4.
REQ-025 pass SHALL change only in DONE, and SHALL hold its value during a subsequent run.
REQ-026 a and b SHALL stay stable throughout WAIT and SAMPLE for a given vector.

Reset
REQ-027 When rst_n=0 at an edge, the FSM SHALL go to IDLE and a=0, b=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, and the settle counter SHALL be cleared.
REQ-028 Reset mid-run SHALL abort the run with no done pulse; the first start after rst_n=1 SHALL begin a fresh run.
REQ-029 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-030 Macro GATE_CHECKER_FAIL_CAPTURE_EN defined: the block SHALL add output fail_idx (2 bits), the vec_idx of the first mismatch in the run, and output fail_obs (2 bits), the {ra,rb} observed at that mismatch.
REQ-031 With the macro defined, fail_idx and fail_obs SHALL be cleared to 0 at reset and at run start, and SHALL be written only on the first error of a run.
REQ-032 Macro not defined: these ports and their registers SHALL be absent, with all other behaviour identical.

Verification
REQ-033 Correct gate stage, SETTLE=1, start pulse -> {a,b} steps through 00,01,10,11; done in cycle 9; pass=1; err_count=0.
REQ-034 ra stuck at 0 -> err_count=1, pass=0; with the macro defined, fail_idx=3 and fail_obs=2'b00.
REQ-035 ra inverted -> err_count=4, pass=0; with the macro defined, fail_idx=0 and fail_obs=2'b11.
REQ-036 SETTLE=3, start asserted again during the run -> done only in cycle 17; a single run executes.
REQ-037 rst_n=0 with vec_idx=2 -> all outputs are 0 next cycle, no done pulse; a new start completes with pass=1.
REQ-038 start held high for 25 cycles with SETTLE=1 -> done pulses in cycles 9 and 19, and err_count is cleared at each run start.

Source files
------------

// File: rtl/gate_vector_checker.sv
// Drives the four {a,b} vectors into an external AND/NAND gate stage and counts responses that disagree.
// Optional first-failure capture ports are enabled with `define GATE_CHECKER_FAIL_CAPTURE_EN.
module gate_vector_checker #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       ra,
    input  logic       rb,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] vec_idx
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    ,
    output logic [1:0] fail_idx,
    output logic [1:0] fail_obs
`endif
);

    // A SETTLE of 0 is treated as 1 so WAIT always lasts at least one cycle.
    localparam logic [3:0] SETTLE_EFF = (SETTLE < 1)  ? 4'd1  :
                                        (SETTLE > 15) ? 4'd15 : 4'(SETTLE);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0] state;
    logic [3:0] cnt;
    logic       mismatch;

    assign mismatch = (ra != (a & b)) || (rb != ~(a & b));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            vec_idx   <= 2'd0;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
            fail_idx  <= 2'd0;
            fail_obs  <= 2'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WAIT;
                        vec_idx   <= 2'd0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        err_count <= 3'd0;
                        busy      <= 1'b1;
                        cnt       <= SETTLE_EFF;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
                        fail_idx  <= 2'd0;
                        fail_obs  <= 2'd0;
`endif
                    end
                end
                WAIT: begin
                    if (cnt <= 4'd1) begin
                        state <= SAMPLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (err_count < 3'd4) begin
                            err_count <= err_count + 3'd1;
                        end
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
                        // An error count of zero here means this is the run's first mismatch.
                        if (err_count == 3'd0) begin
                            fail_idx <= vec_idx;
                            fail_obs <= {ra, rb};
                        end
`endif
                    end
                    if (vec_idx == 2'd3) begin
                        state <= DONE;
                    end else begin
                        vec_idx <= vec_idx + 2'd1;
                        {a, b}  <= vec_idx + 2'd1;
                        cnt     <= SETTLE_EFF;
                        state   <= WAIT;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    pass  <= (err_count == 3'd0);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
